// File: rtl/sub_serial.sv
// sub_serial: bit-serial unsigned subtractor computing a - b, LSB first.
// A single borrow flop ripples between bit slots. The difference is shifted
// into the result register from the top, so after WIDTH shifts bit 0 of the
// result is the first bit that was computed. A one-cycle done pulse follows.
module sub_serial #(
  parameter int         WIDTH = 8,
  parameter logic [1:0] IDLE  = 2'd0,
  parameter logic [1:0] SUB   = 2'd1,
  parameter logic [1:0] DONE  = 2'd2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_SUB  = SUB,
    S_DONE = DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] out_q;
  logic             brw_q;
  logic [CW-1:0]    count_q;

  logic             diff_d;
  logic             brw_d;

  // Full-subtractor slice on the current LSBs of the operand shift registers.
  always_comb begin
    diff_d = a_q[0] ^ b_q[0] ^ brw_q;
    brw_d  = (~a_q[0] & b_q[0]) | (~a_q[0] & brw_q) | (b_q[0] & brw_q);
  end

  // Control FSM and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      brw_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Previous result stays visible until a new operation is loaded.
          if (en) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= 1'b0;
            count_q <= '0;
            out_q   <= '0;
            state_q <= S_SUB;
          end
        end
        S_SUB: begin
          out_q   <= {diff_d, out_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          brw_q   <= brw_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // en is deliberately ignored here; a new load waits for IDLE.
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out    = out_q;
  assign borrow = brw_q;
  assign busy   = (state_q == S_SUB);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed table, hand-written corner sequences and a random
// regression against an arithmetic reference model, at WIDTH 8 and 5.
module tb_sub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en8, borrow8, done8, busy8;
  logic [7:0] a8, b8, out8;
  logic       en5, borrow5, done5, busy5;
  logic [4:0] a5, b5, out5;

  sub_serial #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8),
    .out(out8), .borrow(borrow8), .done(done8), .busy(busy8)
  );

  sub_serial #(.WIDTH(5)) u5 (
    .clk(clk), .rst(rst), .en(en5), .a(a5), .b(b5),
    .out(out5), .borrow(borrow5), .done(done5), .busy(busy5)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic       exp_borrow;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on integers.
  function automatic logic [7:0] ref_diff(input int w, input logic [7:0] x, input logic [7:0] y);
    int m;
    int d;
    m = 1 << w;
    d = ((int'(x) - int'(y)) % m + m) % m;
    return 8'(d);
  endfunction

  function automatic logic ref_borrow(input logic [7:0] x, input logic [7:0] y);
    return (int'(x) < int'(y));
  endfunction

  // One operation: drive a load request, then watch until done.
  // lat is the number of busy cycles seen before done (-1 on timeout).
  task automatic do_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] got_out, output logic got_brw,
                       output int lat, output logic shape_ok);
    logic d;
    logic bz;
    lat      = -1;
    shape_ok = 1'b1;
    @(negedge clk);
    if (w == 8) begin en8 = 1'b1; a8 = av; b8 = bv; end
    else        begin en5 = 1'b1; a5 = av[4:0]; b5 = bv[4:0]; end
    @(negedge clk);
    // Operand changes after the load edge must not matter.
    en8 = 1'b0; en5 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    a5 = 5'($urandom); b5 = 5'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      d  = (w == 8) ? done8 : done5;
      bz = (w == 8) ? busy8 : busy5;
      if (d && bz) shape_ok = 1'b0;
      if (d) begin
        lat = k - 1;
        break;
      end
      if (!bz) shape_ok = 1'b0;
    end
    got_out = (w == 8) ? out8 : {3'b000, out5};
    got_brw = (w == 8) ? borrow8 : borrow5;
  endtask

  initial begin
    logic [7:0] go;
    logic       gb;
    int         lat;
    logic       ok;
    logic [7:0] x, y;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[5] = '{8'h33, 8'h11, 8'h22, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

    rst = 1'b1;
    en8 = 1'b0; a8 = '0; b8 = '0;
    en5 = 1'b0; a5 = '0; b5 = '0;
    #2 rst = 1'b0;
    #1;
    chk("reset_out8",    32'(out8),    32'h0);
    chk("reset_borrow8", 32'(borrow8), 32'h0);
    chk("reset_busy8",   32'(busy8),   32'h0);
    chk("reset_done8",   32'(done8),   32'h0);
    chk("reset_out5",    32'(out5),    32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed table at WIDTH 8.
    for (int i = 0; i < 8; i++) begin
      do_op(8, vecs[i].a, vecs[i].b, go, gb, lat, ok);
      $display("op w=8 a=%02h b=%02h out=%02h borrow=%0d lat=%0d", vecs[i].a, vecs[i].b, go, gb, lat);
      chk("tbl_out",     32'(go),  32'(vecs[i].exp_out));
      chk("tbl_borrow",  32'(gb),  32'(vecs[i].exp_borrow));
      chk("tbl_latency", 32'(lat), 32'd8);
      chk("tbl_busy_shape", 32'(ok), 32'd1);
      @(negedge clk);
      chk("tbl_done_pulse", 32'(done8), 32'd0);
      repeat (2) @(negedge clk);
      chk("tbl_hold_out",    32'(out8),    32'(vecs[i].exp_out));
      chk("tbl_hold_borrow", 32'(borrow8), 32'(vecs[i].exp_borrow));
    end

    // en held high: back-to-back operations, load edges WIDTH+2 apart.
    begin
      int nd = 0, d1 = -1, d2 = -1;
      logic [7:0] r1o = '0, r2o = '0;
      logic       r1b = 1'b0, r2b = 1'b0;
      @(negedge clk);
      en8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
      for (int k = 1; k <= 60; k++) begin
        @(negedge clk);
        if (busy8) begin a8 = 8'($urandom); b8 = 8'($urandom); end
        if (done8) begin
          if (nd == 0) begin
            d1 = k; r1o = out8; r1b = borrow8;
            a8 = 8'h01; b8 = 8'h80;
          end else begin
            d2 = k; r2o = out8; r2b = borrow8;
          end
          nd++;
          if (nd == 2) break;
        end
      end
      en8 = 1'b0;
      $display("op b2b out1=%02h b1=%0d out2=%02h b2=%0d spacing=%0d", r1o, r1b, r2o, r2b, d2 - d1);
      chk("b2b_out1",    32'(r1o), 32'h7F);
      chk("b2b_borrow1", 32'(r1b), 32'h0);
      chk("b2b_out2",    32'(r2o), 32'h81);
      chk("b2b_borrow2", 32'(r2b), 32'h1);
      chk("b2b_spacing", 32'(d2 - d1), 32'd10);
    end

    // Reset in the middle of SUB (count = 4).
    begin
      logic saw_done = 1'b0;
      @(negedge clk);
      en8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C;
      @(negedge clk);
      en8 = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (done8) saw_done = 1'b1;
      end
      rst = 1'b0;
      #1;
      chk("midrst_out",    32'(out8),    32'h0);
      chk("midrst_borrow", 32'(borrow8), 32'h0);
      chk("midrst_busy",   32'(busy8),   32'h0);
      chk("midrst_done",   32'(done8),   32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (done8 || busy8) saw_done = 1'b1;
      end
      $display("op midreset out=%02h borrow=%0d spurious=%0d", out8, borrow8, saw_done);
      chk("midrst_no_done",  32'(saw_done), 32'h0);
      chk("midrst_out_post", 32'(out8),     32'h0);
      do_op(8, 8'h33, 8'h11, go, gb, lat, ok);
      $display("op w=8 a=33 b=11 out=%02h borrow=%0d lat=%0d", go, gb, lat);
      chk("post_rst_out",    32'(go),  32'h22);
      chk("post_rst_borrow", 32'(gb),  32'h0);
      chk("post_rst_lat",    32'(lat), 32'd8);
    end

    // Random regression at both widths.
    for (int w = 8; w >= 5; w -= 3) begin
      for (int i = 0; i < 1000; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        x = 8'($urandom);
        y = 8'($urandom);
        if (w == 5) begin x = x & 8'h1F; y = y & 8'h1F; end
        do_op(w, x, y, go, gb, lat, ok);
        $display("op w=%0d a=%02h b=%02h out=%02h borrow=%0d lat=%0d", w, x, y, go, gb, lat);
        chk("rnd_out",     32'(go),  32'(ref_diff(w, x, y)));
        chk("rnd_borrow",  32'(gb),  32'(ref_borrow(x, y)));
        chk("rnd_latency", 32'(lat), 32'(w));
        chk("rnd_busy_shape", 32'(ok), 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
